// File: rtl/mpu_region_sequencer.sv
// Table-driven MPU region programmer: writes NTAB table entries into the core's MPU,
// optionally scrubs the remaining regions to no-access, and reports pass status.
module mpu_region_sequencer #(
    parameter int unsigned         NREG         = 8,
    parameter int unsigned         IDX_W        = $clog2(NREG),
    parameter int unsigned         NTAB         = 3,
    parameter logic [69*NTAB-1:0]  TABLE        = {NTAB{69'h0}},
    parameter bit                  AUTO_START   = 1'b1,
    parameter bit                  CLEAR_UNUSED = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mpu_lock_i,
    input  logic             mpu_prog_ready_i,
    output logic             mpu_prog_en_o,
    output logic [IDX_W-1:0] mpu_prog_idx_o,
    output logic [31:0]      mpu_prog_base_o,
    output logic [31:0]      mpu_prog_limit_o,
    output logic [2:0]       mpu_prog_perm_o,
    output logic             mpu_prog_user_ok_o,
    output logic             mpu_prog_is_ispace_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             start_rejected_o,
    output logic             lock_abort_o,
    output logic [NTAB-1:0]  err_mask_o
);

    localparam int unsigned ENT_W    = 69;
    localparam int unsigned CUR_W    = IDX_W + 1;
    localparam bit          DO_CLEAR = CLEAR_UNUSED && (NTAB < NREG);

    typedef enum logic [1:0] {S_IDLE, S_PROG, S_CLEAR, S_DONE} state_e;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] limit;
        logic [2:0]  perm;
        logic        user_ok;
        logic        is_ispace;
    } entry_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      base;
        logic [31:0]      limit;
        logic [2:0]       perm;
        logic             user_ok;
        logic             is_ispace;
    } write_t;

    // Payload for region k: the table entry if well formed, else an all-zero no-access region.
    function automatic write_t write_at(input logic [CUR_W-1:0] k);
        write_t w;
        entry_t e;
        w     = '0;
        w.idx = k[IDX_W-1:0];
        for (int unsigned i = 0; i < NTAB; i++) begin
            e = entry_t'(TABLE[ENT_W*i +: ENT_W]);
            if (k == CUR_W'(i) && e.base <= e.limit) begin
                w.base      = e.base;
                w.limit     = e.limit;
                w.perm      = e.perm;
                w.user_ok   = e.user_ok;
                w.is_ispace = e.is_ispace;
            end
        end
        return w;
    endfunction

    state_e            state_q, state_d;
    logic [CUR_W-1:0]  cursor_q, cursor_d;
    write_t            wr_q, wr_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rej_q, rej_d;
    logic              abort_q, abort_d;
    logic [NTAB-1:0]   err_q, err_d;
    logic              auto_q, auto_d;
    logic              xfer;
    logic              last;
    logic [CUR_W-1:0]  cursor_nx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cursor_q <= '0;
            wr_q     <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rej_q    <= 1'b0;
            abort_q  <= 1'b0;
            err_q    <= '0;
            auto_q   <= AUTO_START;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            wr_q     <= wr_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            auto_q   <= auto_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        wr_d      = wr_q;
        en_d      = en_q;
        busy_d    = busy_q;
        done_d    = done_q;
        rej_d     = 1'b0;
        abort_d   = abort_q;
        err_d     = err_q;
        auto_d    = 1'b0;
        xfer      = en_q && mpu_prog_ready_i;
        cursor_nx = cursor_q + CUR_W'(1);
        last      = (state_q == S_PROG) ? (cursor_q == CUR_W'(NTAB - 1))
                                        : (cursor_q == CUR_W'(NREG - 1));

        case (state_q)
            S_IDLE: begin
                if (start_i || auto_q) begin
                    if (mpu_lock_i) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d  = S_PROG;
                        cursor_d = '0;
                        wr_d     = write_at('0);
                        en_d     = 1'b1;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        abort_d  = 1'b0;
                        err_d    = '0;
                    end
                end
            end
            S_PROG, S_CLEAR: begin
                // Lock wins over ready: the presented write is dropped.
                if (mpu_lock_i) begin
                    state_d  = S_IDLE;
                    cursor_d = '0;
                    wr_d     = '0;
                    en_d     = 1'b0;
                    busy_d   = 1'b0;
                    abort_d  = 1'b1;
                end else if (xfer) begin
                    if (state_q == S_PROG) begin
                        for (int unsigned i = 0; i < NTAB; i++) begin
                            if (cursor_q == CUR_W'(i) && write_at(cursor_q) == write_t'({IDX_W'(i), 69'h0})
                                && TABLE[ENT_W*i+37 +: 32] > TABLE[ENT_W*i+5 +: 32]) begin
                                err_d[i] = 1'b1;
                            end
                        end
                    end
                    if (last) begin
                        if (state_q == S_PROG && DO_CLEAR) begin
                            state_d  = S_CLEAR;
                            cursor_d = CUR_W'(NTAB);
                            wr_d     = write_at(CUR_W'(NTAB));
                        end else begin
                            state_d  = S_DONE;
                            cursor_d = '0;
                            wr_d     = '0;
                            en_d     = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end
                    end else begin
                        cursor_d = cursor_nx;
                        wr_d     = write_at(cursor_nx);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mpu_prog_en_o        = en_q;
    assign mpu_prog_idx_o       = wr_q.idx;
    assign mpu_prog_base_o      = wr_q.base;
    assign mpu_prog_limit_o     = wr_q.limit;
    assign mpu_prog_perm_o      = wr_q.perm;
    assign mpu_prog_user_ok_o   = wr_q.user_ok;
    assign mpu_prog_is_ispace_o = wr_q.is_ispace;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign start_rejected_o     = rej_q;
    assign lock_abort_o         = abort_q;
    assign err_mask_o           = err_q;

endmodule

// File: tb/tb_mpu_region_sequencer.sv
// Bench for mpu_region_sequencer: two instances (clean table, table with a malformed entry)
// run in lockstep under random ready/start traffic against a pass-level reference model.
module tb_mpu_region_sequencer;

    localparam int unsigned NREG  = 8;
    localparam int unsigned NTAB  = 3;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned NDUT  = 2;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] limit;
        logic [2:0]  perm;
        logic        user_ok;
        logic        is_ispace;
    } ent_t;

    localparam ent_t E_ROM  = '{base: 32'h0000_0000, limit: 32'h0000_FFFF, perm: 3'b101, user_ok: 1'b1, is_ispace: 1'b1};
    localparam ent_t E_RAM  = '{base: 32'h2000_0000, limit: 32'h2001_FFFF, perm: 3'b011, user_ok: 1'b1, is_ispace: 1'b0};
    localparam ent_t E_MMIO = '{base: 32'h1000_0000, limit: 32'h1000_FFFF, perm: 3'b011, user_ok: 1'b0, is_ispace: 1'b0};
    localparam ent_t E_BAD  = '{base: 32'h3000_0000, limit: 32'h2000_0000, perm: 3'b011, user_ok: 1'b1, is_ispace: 1'b0};
    localparam logic [69*NTAB-1:0] TAB0 = {E_MMIO, E_RAM, E_ROM};
    localparam logic [69*NTAB-1:0] TAB1 = {E_MMIO, E_BAD, E_ROM};

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic mpu_lock_i = 1'b0;
    logic ready_i = 1'b0;

    logic [NDUT-1:0]            en_o, uok_o, isp_o, busy_o, done_o, rej_o, abort_o;
    logic [NDUT-1:0][IDX_W-1:0] idx_o;
    logic [NDUT-1:0][31:0]      base_o, limit_o;
    logic [NDUT-1:0][2:0]       perm_o;
    logic [NDUT-1:0][NTAB-1:0]  err_o;

    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    ent_t tab [NDUT][NTAB];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mpu_region_sequencer #(
            .NREG(NREG), .IDX_W(IDX_W), .NTAB(NTAB),
            .TABLE(g == 0 ? TAB0 : TAB1),
            .AUTO_START(1'b1), .CLEAR_UNUSED(1'b1)
        ) u_dut (
            .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mpu_lock_i(mpu_lock_i),
            .mpu_prog_ready_i(ready_i),
            .mpu_prog_en_o(en_o[g]), .mpu_prog_idx_o(idx_o[g]),
            .mpu_prog_base_o(base_o[g]), .mpu_prog_limit_o(limit_o[g]),
            .mpu_prog_perm_o(perm_o[g]), .mpu_prog_user_ok_o(uok_o[g]),
            .mpu_prog_is_ispace_o(isp_o[g]), .busy_o(busy_o[g]), .done_o(done_o[g]),
            .start_rejected_o(rej_o[g]), .lock_abort_o(abort_o[g]), .err_mask_o(err_o[g])
        );
    end

    // Reference: region k gets table entry k if base<=limit, otherwise (and beyond the table) zeros.
    function automatic logic [71:0] exp_write(input int d, input int k);
        if (k < NTAB && tab[d][k].base <= tab[d][k].limit) return {IDX_W'(k), tab[d][k]};
        return {IDX_W'(k), 69'h0};
    endfunction

    function automatic logic [NTAB-1:0] exp_err(input int d);
        logic [NTAB-1:0] m;
        m = '0;
        for (int k = 0; k < NTAB; k++) m[k] = tab[d][k].base > tab[d][k].limit;
        return m;
    endfunction

    function automatic logic [71:0] obs_write(input int d);
        return {idx_o[d], base_o[d], limit_o[d], perm_o[d], uok_o[d], isp_o[d]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status bits {en, busy, done, start_rejected, lock_abort}.
    task automatic check_status(input string tag, input int d, input logic [4:0] exp);
        check($sformatf("%s_status%0d", tag, d),
              {123'h0, en_o[d], busy_o[d], done_o[d], rej_o[d], abort_o[d]}, {123'h0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check_status(tag, d, 5'b00000);
            check($sformatf("%s_write%0d", tag, d), obs_write(d), 0);
            check($sformatf("%s_err%0d", tag, d), err_o[d], 0);
        end
    endtask

    // One programming pass; the start condition must already be set up for the next edge.
    task automatic run_pass(input int stall_pct, input int lock_at, input int rst_at);
        int ptr;
        int e0;
        ptr = 0;
        step();
        start_i = 1'b0;
        e0 = edges;
        for (int d = 0; d < NDUT; d++) begin
            check_status("accept", d, 5'b11000);
            check($sformatf("accept_err%0d", d), err_o[d], 0);
            check($sformatf("accept_write%0d", d), obs_write(d), exp_write(d, 0));
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ready_i = int'($urandom_range(99)) >= stall_pct;
            start_i = $urandom_range(3) == 0;
            if (ptr == lock_at) begin
                ready_i    = 1'b1;
                mpu_lock_i = 1'b1;
            end
            if (ptr == rst_at) rst_i = 1'b1;
            step();
            start_i = 1'b0;
            if (rst_i) begin
                rst_i = 1'b0;
                check_all_zero("midreset");
                return;
            end
            if (mpu_lock_i) begin
                for (int d = 0; d < NDUT; d++) check_status("lockabort", d, 5'b00001);
                return;
            end
            if (ready_i) ptr++;
            if (ptr == NREG) begin
                for (int d = 0; d < NDUT; d++) begin
                    check_status("done", d, 5'b00100);
                    check($sformatf("done_err%0d", d), err_o[d], exp_err(d));
                end
                if (stall_pct == 0) check("done_latency", edges - e0 + 2, NREG + 2);
                step();
                for (int d = 0; d < NDUT; d++) check_status("postdone", d, 5'b00100);
                return;
            end
            for (int d = 0; d < NDUT; d++) begin
                check_status($sformatf("busy_i%0d", ptr), d, 5'b11000);
                check($sformatf("write_i%0d_d%0d", ptr, d), obs_write(d), exp_write(d, ptr));
            end
        end
        checks++;
        assert (ptr == NREG) else begin
            errors++;
            $error("FAIL pass_timeout observed=%0d expected=%0d", ptr, NREG);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0][0] = E_ROM; tab[0][1] = E_RAM; tab[0][2] = E_MMIO;
        tab[1][0] = E_ROM; tab[1][1] = E_BAD; tab[1][2] = E_MMIO;

        step();
        check_all_zero("reset_a");
        repeat (2) step();
        check_all_zero("reset_b");
        rst_i = 1'b0;

        run_pass(0, -1, -1);

        start_i = 1'b1;
        run_pass(50, -1, -1);

        start_i = 1'b1;
        run_pass(30, 4, -1);

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int d = 0; d < NDUT; d++) check_status("locked_start", d, 5'b00011);
        step();
        for (int d = 0; d < NDUT; d++) check_status("locked_after", d, 5'b00001);

        mpu_lock_i = 1'b0;
        start_i    = 1'b1;
        run_pass(0, -1, -1);

        start_i = 1'b1;
        run_pass(20, -1, 2);
        run_pass(0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
